// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//   Next-PC predictor for the IF stage. A direct-mapped BTB supplies targets and a gshare
//   PHT of 2-bit counters, indexed by PC xor global history, decides conditional branches.
//   Lookup is purely combinational. Training arrives from EX-stage resolution one update
//   per clock.
//
// Ports
//   clk_i            rising-edge clock
//   reset_i          asynchronous active-high reset
//   fetch_pc_i       PC currently being fetched
//   pred_pc_o        predicted next PC (combinational)
//   pred_taken_o     1: pred_pc_o is a BTB target, 0: fetch_pc_i + 4
//   pred_bhsr_o      history used for this lookup (travels down the pipe)
//   upd_valid_i      EX resolved a control-flow instruction this cycle
//   upd_is_branch_i  resolved instruction is a conditional branch
//   upd_is_jump_i    resolved instruction is JAL/JALR
//   upd_pc_i         PC of the resolved instruction
//   upd_taken_i      actual branch outcome (ignored for jumps)
//   upd_target_i     actual taken target
//   upd_bhsr_i       history snapshot that travelled with the resolved instruction
module gshare_branch_predictor #(
  parameter int unsigned IDX_BITS = 5,
  parameter int unsigned TAG_BITS = 30 - IDX_BITS
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [31:0]         fetch_pc_i,
  output logic [31:0]         pred_pc_o,
  output logic                pred_taken_o,
  output logic [IDX_BITS-1:0] pred_bhsr_o,
  input  logic                upd_valid_i,
  input  logic                upd_is_branch_i,
  input  logic                upd_is_jump_i,
  input  logic [31:0]         upd_pc_i,
  input  logic                upd_taken_i,
  input  logic [31:0]         upd_target_i,
  input  logic [IDX_BITS-1:0] upd_bhsr_i
);

  localparam int unsigned Entries = 1 << IDX_BITS;

  logic                valid_q  [Entries];
  logic                valid_d  [Entries];
  logic [TAG_BITS-1:0] tag_q    [Entries];
  logic [TAG_BITS-1:0] tag_d    [Entries];
  logic [31:0]         target_q [Entries];
  logic [31:0]         target_d [Entries];
  logic                is_jmp_q [Entries];
  logic                is_jmp_d [Entries];
  logic [1:0]          cnt_q    [Entries];
  logic [1:0]          cnt_d    [Entries];
  logic [IDX_BITS-1:0] bhsr_q;
  logic [IDX_BITS-1:0] bhsr_d;

  // PC[1:0] never participates in indexing or tag compare.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc_i[1:0], upd_pc_i[1:0]};

  // Lookup
  logic [IDX_BITS-1:0] look_bi;
  logic [IDX_BITS-1:0] look_pi;
  logic [TAG_BITS-1:0] look_tag;
  logic                look_hit;

  always_comb begin
    look_bi      = fetch_pc_i[IDX_BITS+1:2];
    look_pi      = look_bi ^ bhsr_q;
    look_tag     = fetch_pc_i[31:IDX_BITS+2];
    look_hit     = valid_q[look_bi] && (tag_q[look_bi] == look_tag);
    pred_taken_o = look_hit && (is_jmp_q[look_bi] || cnt_q[look_pi][1]);
    pred_pc_o    = pred_taken_o ? target_q[look_bi] : fetch_pc_i + 32'd4;
    pred_bhsr_o  = bhsr_q;
  end

  // Update
  logic [IDX_BITS-1:0] upd_bi;
  logic [IDX_BITS-1:0] upd_pi;
  logic                do_branch;
  logic                do_jump;

  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    target_d  = target_q;
    is_jmp_d  = is_jmp_q;
    cnt_d     = cnt_q;
    bhsr_d    = bhsr_q;
    upd_bi    = upd_pc_i[IDX_BITS+1:2];
    // PHT is trained with the history seen at prediction time, not the current one.
    upd_pi    = upd_bi ^ upd_bhsr_i;
    do_branch = upd_valid_i && upd_is_branch_i;
    do_jump   = upd_valid_i && upd_is_jump_i && !upd_is_branch_i;

    if (do_branch) begin
      if (upd_taken_i) begin
        if (cnt_q[upd_pi] != 2'b11) cnt_d[upd_pi] = cnt_q[upd_pi] + 2'd1;
      end else begin
        if (cnt_q[upd_pi] != 2'b00) cnt_d[upd_pi] = cnt_q[upd_pi] - 2'd1;
      end
      // Rebuild history from the snapshot so wrong-path speculation never leaks in.
      bhsr_d = {upd_bhsr_i[IDX_BITS-2:0], upd_taken_i};
      if (upd_taken_i) begin
        valid_d[upd_bi]  = 1'b1;
        tag_d[upd_bi]    = upd_pc_i[31:IDX_BITS+2];
        target_d[upd_bi] = upd_target_i;
        is_jmp_d[upd_bi] = 1'b0;
      end
    end else if (do_jump) begin
      valid_d[upd_bi]  = 1'b1;
      tag_d[upd_bi]    = upd_pc_i[31:IDX_BITS+2];
      target_d[upd_bi] = upd_target_i;
      is_jmp_d[upd_bi] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        is_jmp_q[i] <= 1'b0;
        cnt_q[i]    <= 2'b01;
      end
      bhsr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      is_jmp_q <= is_jmp_d;
      cnt_q    <= cnt_d;
      bhsr_q   <= bhsr_d;
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] fetch_pc_i;
  logic [31:0] pred_pc_o;
  logic        pred_taken_o;
  logic [4:0]  pred_bhsr_o;
  logic        upd_valid_i;
  logic        upd_is_branch_i;
  logic        upd_is_jump_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic [4:0]  upd_bhsr_i;

  always #5 clk_i = ~clk_i;

  gshare_branch_predictor dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .fetch_pc_i      (fetch_pc_i),
    .pred_pc_o       (pred_pc_o),
    .pred_taken_o    (pred_taken_o),
    .pred_bhsr_o     (pred_bhsr_o),
    .upd_valid_i     (upd_valid_i),
    .upd_is_branch_i (upd_is_branch_i),
    .upd_is_jump_i   (upd_is_jump_i),
    .upd_pc_i        (upd_pc_i),
    .upd_taken_i     (upd_taken_i),
    .upd_target_i    (upd_target_i),
    .upd_bhsr_i      (upd_bhsr_i)
  );

  // Reference model: plain integers, 32 entries, tag = pc / 128, index = (pc / 4) % 32.
  bit          m_valid [32];
  int unsigned m_tag   [32];
  int unsigned m_tgt   [32];
  bit          m_jmp   [32];
  int          m_cnt   [32];
  int unsigned m_hist;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0;
      m_jmp[i]   = 0;
      m_cnt[i]   = 1;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
    end
    m_hist = 0;
  endtask

  task automatic model_predict(input int unsigned pc, output bit tk, output int unsigned npc);
    int unsigned bi, pi;
    bi  = (pc / 4) % 32;
    pi  = bi ^ m_hist;
    tk  = m_valid[bi] && (m_tag[bi] == pc / 128) && (m_jmp[bi] || m_cnt[pi] >= 2);
    npc = tk ? m_tgt[bi] : pc + 4;
  endtask

  task automatic model_update(input bit v, input bit br, input bit jp, input int unsigned pc,
                              input bit tk, input int unsigned tgt, input int unsigned snap);
    int unsigned bi, pi;
    bi = (pc / 4) % 32;
    pi = bi ^ snap;
    if (!v) return;
    if (br) begin
      if (tk) m_cnt[pi] = (m_cnt[pi] == 3) ? 3 : m_cnt[pi] + 1;
      else    m_cnt[pi] = (m_cnt[pi] == 0) ? 0 : m_cnt[pi] - 1;
      m_hist = (snap * 2 + (tk ? 1 : 0)) % 32;
      if (tk) begin
        m_valid[bi] = 1; m_tag[bi] = pc / 128; m_tgt[bi] = tgt; m_jmp[bi] = 0;
      end
    end else if (jp) begin
      m_valid[bi] = 1; m_tag[bi] = pc / 128; m_tgt[bi] = tgt; m_jmp[bi] = 1;
    end
  endtask

  // One clock: drive at posedge+1, compare at posedge+2, then advance both DUT and model.
  task automatic cyc(input string tag, input logic [31:0] fpc, input bit v, input bit br,
                     input bit jp, input logic [31:0] upc, input bit tk, input logic [31:0] tgt,
                     input logic [4:0] snap);
    bit          etk;
    int unsigned enpc;
    logic [31:0] e32;
    fetch_pc_i      = fpc;
    upd_valid_i     = v;
    upd_is_branch_i = br;
    upd_is_jump_i   = jp;
    upd_pc_i        = upc;
    upd_taken_i     = tk;
    upd_target_i    = tgt;
    upd_bhsr_i      = snap;
    #1;
    model_predict(fpc, etk, enpc);
    e32 = enpc;
    chk({tag, ".taken"}, {31'd0, pred_taken_o}, {31'd0, etk});
    chk({tag, ".pc"}, pred_pc_o, e32);
    e32 = m_hist;
    chk({tag, ".bhsr"}, {27'd0, pred_bhsr_o}, e32);
    @(posedge clk_i);
    model_update(v, br, jp, upc, tk, tgt, {27'd0, snap});
    #1;
  endtask

  task automatic idle(input string tag, input logic [31:0] fpc);
    cyc(tag, fpc, 0, 0, 0, 32'h0, 0, 32'h0, 5'd0);
  endtask

  initial begin
    reset_i = 1'b1;
    fetch_pc_i = 32'h40;
    upd_valid_i = 0; upd_is_branch_i = 0; upd_is_jump_i = 0;
    upd_pc_i = 0; upd_taken_i = 0; upd_target_i = 0; upd_bhsr_i = 0;
    model_reset();
    @(posedge clk_i);
    #2;
    // T1: reset state
    chk("t1.taken", {31'd0, pred_taken_o}, 32'd0);
    chk("t1.pc", pred_pc_o, 32'h44);
    chk("t1.bhsr", {27'd0, pred_bhsr_o}, 32'd0);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    // T2: jump training, hit and tag-conflict miss
    cyc("t2.upd", 32'h40, 1, 0, 1, 32'h10, 0, 32'h80, 5'd0);
    #1;
    fetch_pc_i = 32'h10;
    #1;
    chk("t2.hit_pc", pred_pc_o, 32'h80);
    chk("t2.hit_taken", {31'd0, pred_taken_o}, 32'd1);
    @(posedge clk_i);
    #1;
    idle("t2.hit", 32'h10);
    idle("t2.other_tag", 32'h90);

    // T3: one taken branch moves history; lookup uses a different PHT slot
    cyc("t3.upd", 32'h40, 1, 1, 0, 32'h20, 1, 32'h200, 5'd0);
    idle("t3.look", 32'h20);
    chk("t3.pc", pred_pc_o, 32'h24);

    // T4: saturation up and down on PHT slot 8
    for (int i = 0; i < 4; i++) cyc("t4.up", 32'h20, 1, 1, 0, 32'h20, 1, 32'h200, 5'd0);
    cyc("t4.dn1", 32'h20, 1, 1, 0, 32'h20, 0, 32'h200, 5'd0);
    idle("t4.strong", 32'h20);
    chk("t4.strong_pc", pred_pc_o, 32'h200);
    for (int i = 0; i < 5; i++) cyc("t4.dn", 32'h20, 1, 1, 0, 32'h20, 0, 32'h200, 5'd0);
    cyc("t4.wrap", 32'h20, 1, 1, 0, 32'h20, 1, 32'h200, 5'd0);
    idle("t4.floor", 32'h20);
    chk("t4.floor_pc", pred_pc_o, 32'h24);

    // T5: history repaired from snapshot
    cyc("t5.set", 32'h40, 1, 1, 0, 32'h60, 0, 32'h0, 5'b01011);
    chk("t5.bhsr_a", {27'd0, pred_bhsr_o}, 32'b10110);
    cyc("t5.fix", 32'h40, 1, 1, 0, 32'h64, 0, 32'h0, 5'b00011);
    chk("t5.bhsr_b", {27'd0, pred_bhsr_o}, 32'b00110);
    cyc("t5.none", 32'h40, 1, 0, 0, 32'h64, 1, 32'h300, 5'b11111);

    // T6: same-cycle lookup and update
    cyc("t6.same", 32'h30, 1, 0, 1, 32'h30, 0, 32'h100, 5'd0);
    idle("t6.next", 32'h30);
    chk("t6.next_pc", pred_pc_o, 32'h100);

    // Randomised traffic with one asynchronous mid-run reset
    for (int n = 0; n < 400; n++) begin
      logic [31:0] fpc, upc, tgt;
      int unsigned kind;
      fpc  = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      upc  = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      tgt  = $urandom;
      kind = $urandom_range(0, 3);
      cyc("rnd", fpc, kind != 0, kind == 1, kind == 2, upc, 1'($urandom_range(0, 1)), tgt,
          5'($urandom_range(0, 31)));
      if (n == 250) begin
        #2;
        reset_i = 1'b1;
        #1;
        model_reset();
        chk("rst.taken", {31'd0, pred_taken_o}, 32'd0);
        chk("rst.bhsr", {27'd0, pred_bhsr_o}, 32'd0);
        chk("rst.pc", pred_pc_o, fpc + 32'd4);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
